regbus_initiator: RTL and testbench



---
 rtl/regbus_initiator_if.sv | 33 +++
 rtl/regbus_initiator.sv | 156 +++++++++++++++
 tb/tb_regbus_initiator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regbus_initiator_if.sv
// Command port and register-bus signals of regbus_initiator, bundled as one interface.
// Modport master is the initiator's view; modport slave is the view of whoever drives
// commands and returns rdata (sequencer plus register slave, or a testbench).
interface regbus_initiator_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  // command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              done;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  // register bus side
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rdata,
    output cmd_ready, done, rsp_rdata, busy, addr, wdata, write, read
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rdata,
    input  cmd_ready, done, rsp_rdata, busy, addr, wdata, write, read
  );
endinterface

// File: rtl/regbus_initiator.sv
// Register-bus initiator: turns valid/ready commands into SETUP/STROBE bus cycles.
// Latency: accept at T -> strobe T+1..T+2 -> done T+2..T+3 (one more cycle via queue).
// Backpressure: cmd_ready low while a command is in flight, or while the queue is full.
// Ports: clk, rst_n (async active-low), bus (regbus_initiator_if.master: command
//   port cmd_*/done/rsp_rdata/busy and bus port addr/wdata/write/read/rdata).
// Optional macro CMD_FIFO_EN adds a DEPTH-entry command queue in front of the FSM.
module regbus_initiator #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
`ifdef CMD_FIFO_EN
  , parameter int DEPTH = 4
`endif
) (
  input logic                clk,
  input logic                rst_n,
  regbus_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              rw_q, rw_d;

  // command offered to the FSM (straight from the port, or from the queue head)
  logic              issue_vld;
  logic              issue_take;
  logic              issue_rw;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

`ifdef CMD_FIFO_EN
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop, full;

  assign full          = (count_q == FULL_CNT);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = issue_take;
  // Holding off the pop while done is high leaves one idle cycle after every
  // strobe, which spaces queued strobes four cycles apart.
  assign issue_vld     = (count_q != '0) && !done_q;
  assign {issue_rw, issue_addr, issue_wdata} = mem_q[rd_ptr_q];
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic unused_take;

  assign bus.cmd_ready = (state_q == IDLE);
  assign issue_vld     = bus.cmd_valid;
  assign issue_rw      = bus.cmd_rw;
  assign issue_addr    = bus.cmd_addr;
  assign issue_wdata   = bus.cmd_wdata;
  assign bus.busy      = (state_q != IDLE);
  assign unused_take   = issue_take;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    read_d     = read_q;
    done_d     = 1'b0;
    rsp_d      = rsp_q;
    rw_d       = rw_q;
    issue_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_vld) begin
          issue_take = 1'b1;
          addr_d     = issue_addr;
          wdata_d    = issue_rw ? issue_wdata : '0;
          rw_d       = issue_rw;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        write_d = rw_q;
        read_d  = !rw_q;
        state_d = STROBE;
      end
      STROBE: begin
        write_d = 1'b0;
        read_d  = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        done_d  = 1'b1;
        // rdata is only trusted at the edge that closes the read strobe
        if (!rw_q) rsp_d = bus.rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      rsp_q   <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
      done_q  <= done_d;
      rsp_q   <= rsp_d;
      rw_q    <= rw_d;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.write     = write_q;
  assign bus.read      = read_q;
  assign bus.done      = done_q;
  assign bus.rsp_rdata = rsp_q;

endmodule

// File: tb/tb_regbus_initiator.sv
module tb_regbus_initiator;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
  } in_t;

  typedef struct packed {
    logic       rdy;
    logic [1:0] a;
    logic [7:0] wd;
    logic       wr;
    logic       rdd;
    logic       dn;
    logic [7:0] rsp;
    logic       bsy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  regbus_initiator_if #(.ADDR_W(2), .DATA_W(8)) bus ();

  regbus_initiator #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t s;
    s = '{bus.cmd_ready, bus.addr, bus.wdata, bus.write, bus.read,
          bus.done, bus.rsp_rdata, bus.busy};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    bus.cmd_valid = x.v;
    bus.cmd_rw    = x.rw;
    bus.cmd_addr  = x.a;
    bus.cmd_wdata = x.wd;
    bus.rdata     = x.rd;
  endtask

  function automatic vec_t mk(input logic v, input logic rw, input logic [1:0] a,
                              input logic [7:0] wd, input logic [7:0] rd,
                              input logic rdy, input logic [1:0] ea, input logic [7:0] ewd,
                              input logic wr, input logic rdd, input logic dn,
                              input logic [7:0] rsp, input logic bsy);
    vec_t t;
    t.i = '{v, rw, a, wd, rd};
    t.o = '{rdy, ea, ewd, wr, rdd, dn, rsp, bsy};
    return t;
  endfunction

  // count of cycles with any bus or command-side activity while expected quiet
  task automatic quiet_cycles(input int n, input string nm);
    int act = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.write || bus.read || bus.done || bus.busy || !bus.cmd_ready ||
          bus.addr != 2'd0 || bus.wdata != 8'd0) act++;
    end
    chk(nm, act, 0);
  endtask

  localparam out_t RST_OUT = '{1'b1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
  localparam in_t  NO_CMD  = '{1'b0, 1'b0, 2'd0, 8'd0, 8'd0};

  initial begin
    vec_t tbl[20];

    drive(NO_CMD);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", sample(), RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef CMD_FIFO_EN
    //        v  rw a     wd     rd      rdy a     wd     wr rd dn rsp    bsy
    // write a1 0x99
    tbl[0]  = mk(1, 1, 2'd1, 8'h99, 8'h00,  0, 2'd1, 8'h99, 0, 0, 0, 8'h00, 1);
    tbl[1]  = mk(0, 0, 2'd0, 8'h00, 8'h00,  0, 2'd1, 8'h99, 1, 0, 0, 8'h00, 1);
    tbl[2]  = mk(0, 0, 2'd0, 8'h00, 8'h00,  1, 2'd0, 8'h00, 0, 0, 1, 8'h00, 0);
    tbl[3]  = mk(0, 0, 2'd0, 8'h00, 8'h00,  1, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0);
    // read a2, wdata ignored, rdata during SETUP ignored, 0x5A at strobe end
    tbl[4]  = mk(1, 0, 2'd2, 8'h77, 8'h00,  0, 2'd2, 8'h00, 0, 0, 0, 8'h00, 1);
    tbl[5]  = mk(0, 0, 2'd0, 8'h00, 8'hC3,  0, 2'd2, 8'h00, 0, 1, 0, 8'h00, 1);
    tbl[6]  = mk(0, 0, 2'd0, 8'h00, 8'h5A,  1, 2'd0, 8'h00, 0, 0, 1, 8'h5A, 0);
    // write a3 0x11 keeps rsp_rdata, rdata during write strobe ignored
    tbl[7]  = mk(1, 1, 2'd3, 8'h11, 8'hEE,  0, 2'd3, 8'h11, 0, 0, 0, 8'h5A, 1);
    tbl[8]  = mk(0, 0, 2'd0, 8'h00, 8'hEE,  0, 2'd3, 8'h11, 1, 0, 0, 8'h5A, 1);
    tbl[9]  = mk(0, 0, 2'd0, 8'h00, 8'hEE,  1, 2'd0, 8'h00, 0, 0, 1, 8'h5A, 0);
    // cmd_valid held: read a0, write a0 0x42, write a2 0x3C
    tbl[10] = mk(1, 0, 2'd0, 8'h00, 8'h00,  0, 2'd0, 8'h00, 0, 0, 0, 8'h5A, 1);
    tbl[11] = mk(1, 1, 2'd0, 8'h42, 8'h00,  0, 2'd0, 8'h00, 0, 1, 0, 8'h5A, 1);
    tbl[12] = mk(1, 1, 2'd0, 8'h42, 8'h81,  1, 2'd0, 8'h00, 0, 0, 1, 8'h81, 0);
    tbl[13] = mk(1, 1, 2'd0, 8'h42, 8'h00,  0, 2'd0, 8'h42, 0, 0, 0, 8'h81, 1);
    tbl[14] = mk(1, 1, 2'd2, 8'h3C, 8'h00,  0, 2'd0, 8'h42, 1, 0, 0, 8'h81, 1);
    tbl[15] = mk(1, 1, 2'd2, 8'h3C, 8'h00,  1, 2'd0, 8'h00, 0, 0, 1, 8'h81, 0);
    tbl[16] = mk(1, 1, 2'd2, 8'h3C, 8'h00,  0, 2'd2, 8'h3C, 0, 0, 0, 8'h81, 1);
    tbl[17] = mk(0, 0, 2'd0, 8'h00, 8'h00,  0, 2'd2, 8'h3C, 1, 0, 0, 8'h81, 1);
    tbl[18] = mk(0, 0, 2'd0, 8'h00, 8'h00,  1, 2'd0, 8'h00, 0, 0, 1, 8'h81, 0);
    tbl[19] = mk(0, 0, 2'd0, 8'h00, 8'h00,  1, 2'd0, 8'h00, 0, 0, 0, 8'h81, 0);

    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      drive(tbl[n].i);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", n), sample(), tbl[n].o);
    end

    // reset asserted in the middle of a write strobe
    @(negedge clk);
    drive('{1'b1, 1'b1, 2'd1, 8'h55, 8'h00});
    @(posedge clk);
    @(negedge clk);
    drive(NO_CMD);
    @(posedge clk);
    #1;
    chk("mid_rst_strobe_up", bus.write, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", sample(), RST_OUT);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles(6, "mid_rst_quiet");
`else
    begin
      int         n;
      int         k;
      int         ndone;
      logic       stall;
      logic       acc;
      logic       bsy_last;
      logic [7:0] obs[$];
      logic [7:0] got;

      // reset during a write strobe with two commands still queued
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        drive('{1'b1, 1'b1, 2'(c), 8'hA0 + 8'(c), 8'h00});
        @(posedge clk);
      end
      @(negedge clk);
      drive(NO_CMD);
      #1;
      n = 0;
      while (!bus.write && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("fifo_rst_strobe_up", bus.write, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("fifo_rst_async", sample(), RST_OUT);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      quiet_cycles(10, "fifo_rst_quiet");

      // six back-to-back writes: queue fills, stalls, order preserved
      k        = 0;
      ndone    = 0;
      stall    = 1'b0;
      bsy_last = 1'b1;
      @(negedge clk);
      drive('{1'b1, 1'b1, 2'd1, 8'h10, 8'h00});
      for (int cyc = 0; cyc < 80 && ndone < 6; cyc++) begin
        @(negedge clk);
        if (bus.write) obs.push_back(bus.wdata);
        if (bus.done) begin
          ndone++;
          if (ndone == 6) bsy_last = bus.busy;
        end
        if (bus.cmd_valid && !bus.cmd_ready) stall = 1'b1;
        acc = bus.cmd_valid && bus.cmd_ready;
        @(posedge clk);
        #1;
        if (acc) begin
          k++;
          if (k < 6) drive('{1'b1, 1'b1, 2'd1, 8'h10 + 8'(k), 8'h00});
          else       drive(NO_CMD);
        end
      end
      chk("fifo_done_count", ndone, 6);
      chk("fifo_stall_seen", stall, 1'b1);
      chk("fifo_busy_after_last", bsy_last, 1'b0);
      chk("fifo_strobe_count", obs.size(), 6);
      for (int j = 0; j < 6; j++) begin
        got = (j < obs.size()) ? obs[j] : 8'hxx;
        chk($sformatf("fifo_order%0d", j), got, 8'h10 + 8'(j));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
